// File: rtl/mean_shift_accel_udiv_seq.sv
// Iterative unsigned restoring divider for the mean-shift centre update.
// Retires one quotient bit per enabled cycle; ce freezes every register.
module mean_shift_accel_udiv_seq #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic [1:0]            state_dbg
);

  // Handshake: a transfer happens on a rising clk edge where valid and ready
  // are both high; ce is folded into in_ready and into the output transfer.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(DIVIDEND_W + 1);

  logic [1:0]            state;
  logic [DIVIDEND_W-1:0] q_reg;
  logic [DIVISOR_W-1:0]  d_reg;
  // Partial remainder stays below the divisor, so its extra top bit is always
  // zero and only the low DIVISOR_W bits are stored.
  logic [DIVISOR_W-1:0]  r_reg;
  logic [CW-1:0]         counter;

  logic [DIVISOR_W:0]    trial;
  logic                  fits;
  logic [DIVISOR_W-1:0]  r_next;
  logic [DIVIDEND_W-1:0] q_next;

  always_comb begin
    trial  = {r_reg, q_reg[DIVIDEND_W-1]};
    fits   = (trial >= {1'b0, d_reg});
    // Modulo-2^DIVISOR_W subtraction is exact because the true difference < D.
    r_next = fits ? (trial[DIVISOR_W-1:0] - d_reg) : trial[DIVISOR_W-1:0];
    q_next = {q_reg[DIVIDEND_W-2:0], fits};
  end

  assign in_ready  = (state == S_IDLE) && ce;
  assign out_valid = (state == S_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      counter     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              state       <= S_DONE;
              quotient    <= '1;
              remainder   <= dividend[DIVISOR_W-1:0];
              div_by_zero <= 1'b1;
            end else begin
              state   <= S_CALC;
              q_reg   <= dividend;
              d_reg   <= divisor;
              r_reg   <= '0;
              counter <= CW'(DIVIDEND_W);
            end
          end
        end
        S_CALC: begin
          q_reg   <= q_next;
          r_reg   <= r_next;
          counter <= counter - CW'(1);
          if (counter == CW'(1)) begin
            state       <= S_DONE;
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mean_shift_accel_udiv_seq.sv
// Bench for mean_shift_accel_udiv_seq: directed cases then randomized traffic
// checked against plain-arithmetic division results.
module tb_mean_shift_accel_udiv_seq;
  localparam int DW = 32;
  localparam int SW = 16;
  localparam int EW = DW + SW + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ce;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  mean_shift_accel_udiv_seq #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] ref_result(input logic [DW-1:0] a, input logic [SW-1:0] b);
    logic [DW-1:0] bq;
    logic [DW-1:0] rr;
    if (b == '0) return {{DW{1'b1}}, a[SW-1:0], 1'b1};
    bq = {{(DW-SW){1'b0}}, b};
    rr = a % bq;
    return {a / bq, rr[SW-1:0], 1'b0};
  endfunction

  task automatic start(input logic [DW-1:0] a, input logic [SW-1:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("start_in_ready", 64'(in_ready), 64'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 200);
  endtask

  task automatic check_result(input string tag, input logic [DW-1:0] a, input logic [SW-1:0] b);
    check(tag, 64'({quotient, remainder, div_by_zero}), 64'(ref_result(a, b)));
  endtask

  task automatic pop_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_popped"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_directed(input string tag, input logic [DW-1:0] a,
                              input logic [SW-1:0] b, input int lat);
    int n;
    start(a, b);
    wait_done(n);
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check_result({tag, "_result"}, a, b);
    pop_result(tag);
  endtask

  initial begin
    int n;
    int accepted;
    int cyc;
    logic [EW-1:0] e;
    logic [DW-1:0] hq;
    logic [SW-1:0] hr;

    reset_n = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", 64'({quotient, remainder, div_by_zero}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    run_directed("t1_1000_div_7", 32'd1000, 16'd7, 32);
    check("t1_quotient", 64'(quotient), 64'd142);
    check("t1_remainder", 64'(remainder), 64'd6);
    run_directed("t2_div_zero", 32'h1234_5678, 16'd0, 1);
    check("t2_quotient", 64'(quotient), 64'hFFFF_FFFF);
    check("t2_remainder", 64'(remainder), 64'h5678);
    run_directed("t3_max_div_1", 32'hFFFF_FFFF, 16'd1, 32);
    run_directed("t3_max_div_max", 32'hFFFF_FFFF, 16'hFFFF, 32);
    check("t3_max_div_max_q", 64'(quotient), 64'h0001_0001);
    run_directed("t3_5_div_9", 32'd5, 16'd9, 32);
    run_directed("t3_0_div_3", 32'd0, 16'd3, 32);

    // Backpressure in DONE, then back-to-back accept.
    start(32'd50000, 16'd123);
    wait_done(n);
    check("t4_latency", 64'(n), 64'd32);
    hq = quotient;
    hr = remainder;
    repeat (5) begin
      tick();
      check("t4_hold_valid", 64'(out_valid), 64'd1);
      check("t4_hold_in_ready", 64'(in_ready), 64'd0);
      check("t4_hold_result", 64'({quotient, remainder}), 64'({hq, hr}));
    end
    check_result("t4_result", 32'd50000, 16'd123);
    dividend = 32'd777; divisor = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_after_xfer_valid", 64'(out_valid), 64'd0);
    check("t4_after_xfer_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("t4_accepted", 64'(in_ready), 64'd0);
    wait_done(n);
    check("t4_next_latency", 64'(n), 64'd32);
    check_result("t4_next_result", 32'd777, 16'd5);
    pop_result("t4_next");

    // ce stall mid-calculation.
    start(32'd1000, 16'd7);
    repeat (10) tick();
    ce = 1'b0;
    repeat (4) begin
      tick();
      check("t5_stall_valid", 64'(out_valid), 64'd0);
      check("t5_stall_in_ready", 64'(in_ready), 64'd0);
    end
    ce = 1'b1;
    wait_done(n);
    check("t5_latency", 64'(n + 14), 64'd36);
    check_result("t5_result", 32'd1000, 16'd7);
    pop_result("t5");

    // Async reset mid-calculation.
    start(32'd1000, 16'd7);
    repeat (10) tick();
    #2 reset_n = 1'b0;
    #1;
    check("t6_reset_outputs", 64'({quotient, remainder, div_by_zero}), 64'd0);
    check("t6_reset_valid", 64'(out_valid), 64'd0);
    #2 reset_n = 1'b1;
    tick();
    check("t6_in_ready", 64'(in_ready), 64'd1);
    run_directed("t6_100_div_10", 32'd100, 16'd10, 32);

    // Randomized traffic.
    accepted = 0;
    cyc = 0;
    while ((accepted < 800 || exp_q.size() > 0) && cyc < 60000) begin
      if (accepted < 800) begin
        in_valid = ($urandom_range(0, 99) < 60);
        dividend = ($urandom_range(0, 4) == 0) ? DW'($urandom_range(0, 300)) : DW'($urandom);
        case ($urandom_range(0, 9))
          0:       divisor = '0;
          1:       divisor = 16'd1;
          2, 3:    divisor = SW'($urandom_range(1, 15));
          default: divisor = SW'($urandom);
        endcase
      end else begin
        in_valid = 1'b0;
      end
      ce        = ($urandom_range(0, 99) < 80);
      out_ready = ($urandom_range(0, 99) < 70);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_result(dividend, divisor));
        accepted++;
      end
      if (out_valid && out_ready && ce) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rand_result", 64'({quotient, remainder, div_by_zero}), 64'(e));
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0; ce = 1'b1;
    check("rand_accepted", 64'(accepted), 64'd800);
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
